// File: rtl/ntt_ctrl.sv
// rtl/ntt_ctrl.sv - in-place NTT/INTT sequencer for a single butterfly unit
// Issues N/2 butterflies per stage, drains the read/butterfly pipeline, repeats LOG_N times.
module ntt_ctrl #(
  parameter int LOG_N  = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [LOG_N-1:0] rd_addr_a_o,
  output logic [LOG_N-1:0] rd_addr_b_o,
  output logic [LOG_N-1:0] tw_addr_o,
  output logic             sel_butterfly_o,
  output logic             sel_red_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_a_o,
  output logic [LOG_N-1:0] wr_addr_b_o
);

  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int L    = RD_LAT + BF_LAT;
  localparam int W    = LOG_N + 1;
  localparam int SW   = $clog2(LOG_N + 1);
  localparam int JW   = LOG_N - 1;
  localparam int DW   = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic             mode_q;
  logic [SW-1:0]    stage;
  logic [JW-1:0]    j;
  logic [DW-1:0]    dcnt;
  logic             red_q;

  logic             iss;
  logic             iss_m;
  logic [SW-1:0]    iss_s;
  logic [JW-1:0]    iss_j;
  logic [3*LOG_N-1:0] iss_vec;

  logic [RD_LAT-1:0] selb_sr;
  logic [RD_LAT-1:0] selr_sr;
  logic [L-1:0]      wen_sr;
  logic [LOG_N-1:0]  wa_sr [L];
  logic [LOG_N-1:0]  wb_sr [L];

  // Forward (CT) spans shrink from N/2 down to 1; inverse (GS) spans grow from 1 up to N/2.
  function automatic logic [3*LOG_N-1:0] gen(input logic m, input logic [SW-1:0] s,
                                             input logic [JW-1:0] jv);
    logic [W-1:0] jj, len, k, off, a, b, tw;
    int sh;
    jj  = W'(jv);
    sh  = m ? int'(s) : LOG_N - 1 - int'(s);
    len = W'(1) << sh;
    k   = jj >> sh;
    off = jj & (len - W'(1));
    a   = (k << (sh + 1)) + off;
    b   = a + len;
    tw  = m ? ((W'(N) >> s) - W'(1) - k) : ((W'(1) << s) + k);
    return {LOG_N'(a), LOG_N'(b), LOG_N'(tw)};
  endfunction

  // Decide what is issued in the next cycle so addresses leave this block registered.
  always_comb begin
    iss   = 1'b0;
    iss_m = mode_q;
    iss_s = stage;
    iss_j = '0;
    case (state)
      IDLE: if (start_i) begin
        iss   = 1'b1;
        iss_m = mode_i;
        iss_s = '0;
      end
      ISSUE: if (j != JW'(HALF - 1)) begin
        iss   = 1'b1;
        iss_j = j + 1'b1;
      end
      DRAIN: if (dcnt == DW'(L - 1) && stage != SW'(LOG_N - 1)) begin
        iss   = 1'b1;
        iss_s = stage + 1'b1;
      end
      default: ;
    endcase
    iss_vec = gen(iss_m, iss_s, iss_j);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      stage       <= '0;
      j           <= '0;
      dcnt        <= '0;
      red_q       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      tw_addr_o   <= '0;
      selb_sr     <= '0;
      selr_sr     <= '0;
      wen_sr      <= '0;
      for (int i = 0; i < L; i++) begin
        wa_sr[i] <= '0;
        wb_sr[i] <= '0;
      end
    end else begin
      rd_en_o <= iss;
      {rd_addr_a_o, rd_addr_b_o, tw_addr_o} <= iss ? iss_vec : '0;
      red_q   <= iss && (iss_s == SW'(LOG_N - 1));

      selb_sr[0] <= rd_en_o & mode_q;
      selr_sr[0] <= rd_en_o & red_q;
      for (int i = 1; i < RD_LAT; i++) begin
        selb_sr[i] <= selb_sr[i-1];
        selr_sr[i] <= selr_sr[i-1];
      end
      wen_sr[0] <= rd_en_o;
      wa_sr[0]  <= rd_addr_a_o;
      wb_sr[0]  <= rd_addr_b_o;
      for (int i = 1; i < L; i++) begin
        wen_sr[i] <= wen_sr[i-1];
        wa_sr[i]  <= wa_sr[i-1];
        wb_sr[i]  <= wb_sr[i-1];
      end

      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state  <= ISSUE;
          mode_q <= mode_i;
          stage  <= '0;
          j      <= '0;
          busy_o <= 1'b1;
        end
        ISSUE: if (j == JW'(HALF - 1)) begin
          state <= DRAIN;
          dcnt  <= '0;
        end else begin
          j <= j + 1'b1;
        end
        DRAIN: if (dcnt == DW'(L - 1)) begin
          if (stage == SW'(LOG_N - 1)) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state <= ISSUE;
            stage <= stage + 1'b1;
            j     <= '0;
          end
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_butterfly_o = selb_sr[RD_LAT-1];
  assign sel_red_o       = selr_sr[RD_LAT-1];
  assign wr_en_o         = wen_sr[L-1];
  assign wr_addr_a_o     = wa_sr[L-1];
  assign wr_addr_b_o     = wb_sr[L-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb/tb_ntt_ctrl.sv - self-checking bench for ntt_ctrl
// Expected outputs come from a per-cycle timeline model built from the transform's index arithmetic.
module tb_ntt_ctrl;

  localparam int LOG_N  = 8;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 0;
  localparam int NN     = 1 << LOG_N;
  localparam int HALF   = NN / 2;
  localparam int L      = RD_LAT + BF_LAT;
  localparam int TOT    = LOG_N * (HALF + L);
  localparam int CAP    = TOT + 8;

  logic clk = 1'b0;
  logic rst_i, start_i, mode_i;
  logic busy_o, done_o, rd_en_o, sel_butterfly_o, sel_red_o, wr_en_o;
  logic [LOG_N-1:0] rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic busy, done, rd_en;
    logic [LOG_N-1:0] a, b, tw;
    logic selb, selr, wr_en;
    logic [LOG_N-1:0] wa, wb;
  } ov_t;

  typedef struct packed {
    logic en;
    logic [LOG_N-1:0] a, b, tw;
    logic red;
  } iss_t;

  ov_t dut_now;
  ov_t hist [CAP];

  ntt_ctrl #(.LOG_N(LOG_N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o), .tw_addr_o(tw_addr_o),
    .sel_butterfly_o(sel_butterfly_o), .sel_red_o(sel_red_o), .wr_en_o(wr_en_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
  );

  always #5 clk = ~clk;

  assign dut_now = {busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
                    sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o};

  // Butterfly issued in cycle c after the start edge (c = 1 is the first busy cycle).
  function automatic iss_t issue_at(int c, logic m);
    iss_t x;
    int p, s, j, len, k, a;
    x = '0;
    if (c < 1) return x;
    p = c - 1;
    s = p / (HALF + L);
    j = p % (HALF + L);
    if (s >= LOG_N || j >= HALF) return x;
    len  = m ? (1 << s) : (NN >> (s + 1));
    k    = j / len;
    a    = 2 * k * len + j % len;
    x.en = 1'b1;
    x.a  = LOG_N'(a);
    x.b  = LOG_N'(a + len);
    x.tw = m ? LOG_N'((NN >> s) - 1 - k) : LOG_N'((1 << s) + k);
    x.red = (s == LOG_N - 1);
    return x;
  endfunction

  function automatic ov_t model_out(int c, logic m);
    iss_t i0, i1, i2;
    ov_t o;
    i0 = issue_at(c, m);
    i1 = issue_at(c - RD_LAT, m);
    i2 = issue_at(c - L, m);
    o.busy  = (c >= 1 && c <= TOT);
    o.done  = (c == TOT + 1);
    o.rd_en = i0.en;
    o.a     = i0.a;
    o.b     = i0.b;
    o.tw    = i0.tw;
    o.selb  = i1.en & m;
    o.selr  = i1.en & i1.red;
    o.wr_en = i2.en;
    o.wa    = i2.a;
    o.wb    = i2.b;
    return o;
  endfunction

  task automatic capture(input logic m, input bit rnd, input int ncyc);
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      hist[c] = dut_now;
      if (rnd && c <= TOT + 1) begin
        start_i = 1'($urandom % 2);
        mode_i  = 1'($urandom % 2);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_now !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", dut_now);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (dut_now !== '0 || busy_o !== 1'b0) begin
        failures++; $display("FAIL idle_outputs cyc=%0d got=%h want=0", i, dut_now);
      end
    end
  endtask

  task automatic test_forward();
    int nf = 0;
    capture(1'b0, 1'b0, TOT + 4);
    for (int c = 1; c <= TOT + 4; c++) begin
      checks++;
      if (hist[c] !== model_out(c, 1'b0)) begin
        failures++; nf++;
        $display("FAIL fwd_timeline c=%0d got=%h want=%h", c, hist[c], model_out(c, 1'b0));
        if (nf > 10) break;
      end
    end
    checks++;
    if ({hist[1].a, hist[1].b, hist[1].tw} !== {8'd0, 8'd128, 8'd1}) begin
      failures++; $display("FAIL fwd_first got=%0d/%0d/%0d want=0/128/1", hist[1].a, hist[1].b, hist[1].tw);
    end
    checks++;
    if ({hist[128].a, hist[128].b} !== {8'd127, 8'd255}) begin
      failures++; $display("FAIL fwd_128th got=%0d/%0d want=127/255", hist[128].a, hist[128].b);
    end
    checks++;
    if ({hist[130].rd_en, hist[130].a, hist[130].b, hist[130].tw} !== {1'b1, 8'd0, 8'd64, 8'd2}) begin
      failures++; $display("FAIL fwd_stage1 got=%0d/%0d/%0d want=0/64/2", hist[130].a, hist[130].b, hist[130].tw);
    end
    checks++;
    if ({hist[904].rd_en, hist[904].a, hist[904].b, hist[904].tw} !== {1'b1, 8'd0, 8'd1, 8'd128}) begin
      failures++; $display("FAIL fwd_stage7 got=%0d/%0d/%0d want=0/1/128", hist[904].a, hist[904].b, hist[904].tw);
    end
    checks++;
    if ({hist[1032].busy, hist[1033].busy, hist[1033].done, hist[1032].done} !== 4'b1010) begin
      failures++; $display("FAIL fwd_done_timing got=%b want=1010",
                           {hist[1032].busy, hist[1033].busy, hist[1033].done, hist[1032].done});
    end
    checks++;
    if ({hist[2].wr_en, hist[2].wa, hist[2].wb} !== {1'b1, 8'd0, 8'd128}) begin
      failures++; $display("FAIL wb_first got=%b/%0d/%0d want=1/0/128", hist[2].wr_en, hist[2].wa, hist[2].wb);
    end
    checks++;
    if ({hist[129].rd_en, hist[129].wr_en, hist[130].rd_en, hist[130].wr_en} !== 4'b0110) begin
      failures++; $display("FAIL stage_gap got=%b want=0110",
                           {hist[129].rd_en, hist[129].wr_en, hist[130].rd_en, hist[130].wr_en});
    end
  endtask

  task automatic test_inverse();
    int nf = 0;
    capture(1'b1, 1'b0, TOT + 4);
    for (int c = 1; c <= TOT + 4; c++) begin
      checks++;
      if (hist[c] !== model_out(c, 1'b1)) begin
        failures++; nf++;
        $display("FAIL inv_timeline c=%0d got=%h want=%h", c, hist[c], model_out(c, 1'b1));
        if (nf > 10) break;
      end
    end
    checks++;
    if ({hist[1].a, hist[1].b, hist[1].tw} !== {8'd0, 8'd1, 8'd255}) begin
      failures++; $display("FAIL inv_first got=%0d/%0d/%0d want=0/1/255", hist[1].a, hist[1].b, hist[1].tw);
    end
    checks++;
    if ({hist[904].a, hist[904].b, hist[904].tw} !== {8'd0, 8'd128, 8'd1}) begin
      failures++; $display("FAIL inv_stage7 got=%0d/%0d/%0d want=0/128/1", hist[904].a, hist[904].b, hist[904].tw);
    end
    checks++;
    if ({hist[1].selb, hist[2].selb} !== 2'b01) begin
      failures++; $display("FAIL inv_sel_bf got=%b want=01", {hist[1].selb, hist[2].selb});
    end
    checks++;
    if ({hist[2].selr, hist[903].selr, hist[905].selr, hist[1033].selr} !== 4'b0010) begin
      failures++; $display("FAIL inv_sel_red got=%b want=0010",
                           {hist[2].selr, hist[903].selr, hist[905].selr, hist[1033].selr});
    end
  endtask

  task automatic test_start_ignored();
    int nf = 0;
    int ndone = 0;
    logic m;
    m = 1'($urandom % 2);
    capture(m, 1'b1, TOT + 6);
    for (int c = 1; c <= TOT + 6; c++) begin
      if (hist[c].done === 1'b1) ndone++;
      checks++;
      if (hist[c] !== model_out(c, m)) begin
        failures++; nf++;
        $display("FAIL noisy_timeline c=%0d got=%h want=%h", c, hist[c], model_out(c, m));
        if (nf > 10) break;
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++; $display("FAIL noisy_done_count got=%0d want=1", ndone);
    end
  endtask

  task automatic test_reset_midrun();
    logic m, m2;
    int nw = 0;
    m = 1'($urandom % 2);
    capture(m, 1'b0, 427);
    checks++;
    if (dut_now !== model_out(428, m)) begin
      failures++; $display("FAIL pre_abort c=428 got=%h want=%h", dut_now, model_out(428, m));
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_now !== '0) begin
      failures++; $display("FAIL abort_outputs got=%h want=0", dut_now);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0) nw++;
    end
    checks++;
    if (nw !== 0) begin
      failures++; $display("FAIL abort_quiet bad_cycles=%0d want=0", nw);
    end
    m2 = 1'($urandom % 2);
    capture(m2, 1'b0, 4);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (hist[c] !== model_out(c, m2)) begin
        failures++; $display("FAIL restart c=%0d got=%h want=%h", c, hist[c], model_out(c, m2));
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_start_ignored();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
